// File: rtl/zbt_pattern_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : zbt_pattern_gen_if
// Description : Write bus between the pattern generator and a dual-channel
//               ZBT memory: one shared address, two data words, valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface zbt_pattern_gen_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 36
);
    logic              wr_en;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data0;
    logic [DATA_W-1:0] wr_data1;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data0,
        output wr_data1,
        input  wr_ready
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data0,
        input  wr_data1,
        output wr_ready
    );
endinterface
`default_nettype wire

// File: rtl/zbt_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : zbt_pattern_gen
// Description : Fills one or more frame buffers in ZBT memory with a test
//               pattern (checker, solid, bars or address ramp), one beat per
//               cycle under valid/ready flow control.
// Revision    : 1.0 - initial release
// ============================================================================
module zbt_pattern_gen #(
    parameter int              H_ACTIVE   = 640,
    parameter int              V_ACTIVE   = 480,
    parameter int              ADDR_W     = 20,
    parameter int              DATA_W     = 36,
    parameter int              NUM_BUFS   = 2,
    parameter int              BUF_STRIDE = 307200,
    parameter int              CHECK_LOG2 = 4,
    parameter logic [DATA_W-1:0] FG0      = DATA_W'(36'hFFC63FFC6),
    parameter logic [DATA_W-1:0] BG0      = DATA_W'(36'h008400084),
    parameter logic [DATA_W-1:0] FG1      = DATA_W'(36'hFF843FF84),
    parameter logic [DATA_W-1:0] BG1      = DATA_W'(36'h008400084)
) (
    input  wire logic                clock,
    input  wire logic                reset_n,
    input  wire logic                start,
    input  wire logic                abort,
    input  wire logic [1:0]          mode,
    input  wire logic [NUM_BUFS-1:0] buf_mask,
    zbt_pattern_gen_if.master        wr,
    output logic                     busy,
    output logic                     done
);

    localparam int     c_x_w      = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int     c_y_w      = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int     c_l_w      = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1;
    // Widest untruncated address: base of the last buffer plus one frame.
    localparam longint c_max_addr = longint'(NUM_BUFS - 1) * longint'(BUF_STRIDE)
                                  + longint'(V_ACTIVE) * longint'(H_ACTIVE);
    localparam int     c_span_w   = $clog2(c_max_addr + 1);
    localparam int     c_full_w   = (c_span_w > ADDR_W) ? c_span_w : ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [c_x_w-1:0]    r_x;
    logic [c_y_w-1:0]    r_y;
    logic [c_l_w-1:0]    r_loc;
    logic [1:0]          r_mode;
    logic [NUM_BUFS-1:0] r_mask;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data0;
    logic [DATA_W-1:0]   r_data1;

    logic [c_x_w-1:0]    w_nx;
    logic [c_y_w-1:0]    w_ny;
    logic [c_l_w-1:0]    w_nloc;
    logic                w_last;
    logic [c_l_w-1:0]    w_first_loc;

    logic                w_take_start;
    logic                w_load;
    logic                w_adv;
    logic [c_x_w-1:0]    w_cx;
    logic [c_y_w-1:0]    w_cy;
    logic [c_l_w-1:0]    w_cloc;
    logic [1:0]          w_cmode;

    logic [31:0]         w_k;
    logic                w_xb;
    logic                w_yb;
    logic                w_sel;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_d0;
    logic [DATA_W-1:0]   w_d1;

    // Scan successor of the beat currently on the bus; w_last flags the
    // final pixel of the last selected buffer.
    always_comb begin
        w_nx   = r_x;
        w_ny   = r_y;
        w_nloc = r_loc;
        w_last = 1'b0;
        if (r_x != c_x_w'(H_ACTIVE - 1)) begin
            w_nx = r_x + 1'b1;
        end else if (r_y != c_y_w'(V_ACTIVE - 1)) begin
            w_nx = '0;
            w_ny = r_y + 1'b1;
        end else begin
            w_nx   = '0;
            w_ny   = '0;
            w_last = 1'b1;
            // Descending scan so the lowest qualifying buffer wins.
            for (int i = NUM_BUFS - 1; i >= 0; i--) begin
                if (r_mask[i] && (i > int'(r_loc))) begin
                    w_nloc = c_l_w'(i);
                    w_last = 1'b0;
                end
            end
        end
    end

    // Lowest set bit of the incoming mask selects the first buffer.
    always_comb begin
        w_first_loc = '0;
        for (int i = NUM_BUFS - 1; i >= 0; i--) begin
            if (buf_mask[i]) begin
                w_first_loc = c_l_w'(i);
            end
        end
    end

    // Choose the coordinates of the beat to present after the next edge:
    // either the first pixel of a new fill or the successor of the current one.
    always_comb begin
        w_take_start = (r_state == S_IDLE) && start;
        w_load       = w_take_start && (|buf_mask);
        w_adv        = (r_state == S_RUN) && !abort && wr.wr_ready && !w_last;
        w_cx         = w_load ? '0          : w_nx;
        w_cy         = w_load ? '0          : w_ny;
        w_cloc       = w_load ? w_first_loc : w_nloc;
        w_cmode      = w_load ? mode        : r_mode;
    end

    // Address and pattern data for the candidate pixel.
    always_comb begin
        w_addr = ADDR_W'(c_full_w'(w_cloc) * c_full_w'(BUF_STRIDE)
                       + c_full_w'(w_cy) * c_full_w'(H_ACTIVE)
                       + c_full_w'(w_cx));
        // Square size doubles with buffer index; bits beyond the counter
        // width read as zero.
        w_k    = 32'(CHECK_LOG2) + 32'(w_cloc);
        w_xb   = |(w_cx & (c_x_w'(1) << w_k));
        w_yb   = |(w_cy & (c_y_w'(1) << w_k));
        case (w_cmode)
            2'd0:    w_sel = w_xb ^ w_yb;
            2'd1:    w_sel = 1'b1;
            2'd2:    w_sel = w_xb;
            default: w_sel = 1'b0;
        endcase
        w_d0 = w_sel ? FG0 : BG0;
        w_d1 = w_sel ? FG1 : BG1;
        if (w_cmode == 2'd3) begin
            w_d0 = DATA_W'(w_addr);
            w_d1 = DATA_W'(w_addr);
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort overrides acceptance of the final beat.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (|buf_mask) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (wr.wr_ready && w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Scan position and registered bus beat; held while the memory stalls.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_loc   <= '0;
            r_mode  <= '0;
            r_mask  <= '0;
            r_addr  <= '0;
            r_data0 <= '0;
            r_data1 <= '0;
        end else begin
            if (w_take_start) begin
                r_mode <= mode;
                r_mask <= buf_mask;
            end
            if (w_load || w_adv) begin
                r_x     <= w_cx;
                r_y     <= w_cy;
                r_loc   <= w_cloc;
                r_addr  <= w_addr;
                r_data0 <= w_d0;
                r_data1 <= w_d1;
            end
        end
    end

    assign wr.wr_en    = (r_state == S_RUN);
    assign wr.wr_addr  = r_addr;
    assign wr.wr_data0 = r_data0;
    assign wr.wr_data1 = r_data1;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: doc/zbt_pattern_gen.md
ZBT_PATTERN_GEN -- requirements
Module: zbt_pattern_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning): H_ACTIVE, 640, pixels per line; V_ACTIVE, 480, lines per buffer; ADDR_W, 20, address width; DATA_W, 36, word width; NUM_BUFS, 2, frame buffers, 1..4; BUF_STRIDE, 307200, words between buffer bases; CHECK_LOG2, 4, base checker-square log2 size.
REQ-002 Colour parameters SHALL be FG0, BG0 (channel 0) and FG1, BG1 (channel 1), DATA_W bits each, defaults 36'hFFC63FFC6, 36'h008400084, 36'hFF843FF84, 36'h008400084.
REQ-003 Clock and reset SHALL be: one clock; reset is asynchronous and active-low, ports clock (input, 1) and reset_n (input, 1).
REQ-004 Ports SHALL be: start in 1, begin fill; abort in 1, cancel fill; mode in 2, pattern select; buf_mask in NUM_BUFS, buffers to fill; wr_ready in 1, memory accepts beat.
REQ-005 Ports SHALL be: wr_en out 1, beat valid; wr_addr out ADDR_W, shared address for both channels; wr_data0 out DATA_W; wr_data1 out DATA_W; busy out 1; done out 1, single-cycle completion pulse.

Function
REQ-006 The FSM SHALL have states IDLE, RUN, DONE; encoding is free.
REQ-007 In IDLE with start=1 the block SHALL capture mode and buf_mask, set x=y=0, select loc = lowest set mask bit, and enter RUN; if buf_mask=0 it SHALL enter DONE directly.
REQ-008 start SHALL be ignored outside IDLE; mode and buf_mask SHALL be ignored except at accepted start.
REQ-009 The first beat SHALL appear on wr_en/wr_addr/wr_data* in the cycle after start is sampled (latency 1).
REQ-010 A beat SHALL be accepted on a clock edge where wr_en=1 and wr_ready=1; while wr_en=1 and wr_ready=0, wr_addr, wr_data0, wr_data1 and wr_en SHALL hold unchanged.
REQ-011 With wr_ready held high the block SHALL sustain one accepted beat per cycle with no bubbles, including across line and buffer boundaries.
REQ-012 wr_addr SHALL equal (loc*BUF_STRIDE + y*H_ACTIVE + x) truncated to ADDR_W, computed with sufficient internal width before truncation.
REQ-013 Scan order SHALL be x 0..H_ACTIVE-1 within y 0..V_ACTIVE-1 within ascending set loc bits; at x=H_ACTIVE-1 x wraps to 0 and y increments; at the last pixel of a buffer x,y reset to 0 and loc advances to the next set mask bit.
REQ-014 Mode 0 (checker): k=CHECK_LOG2+loc; sel = x[k] XOR y[k]; sel=1 gives FG0/FG1, else BG0/BG1 on wr_data0/wr_data1.
REQ-015 Mode 1 (solid): wr_data0=FG0, wr_data1=FG1.
REQ-016 Mode 2 (bars): sel = x[CHECK_LOG2+loc]; colours as REQ-014.
REQ-017 Mode 3 (ramp): wr_data0 = wr_data1 = wr_addr zero-extended to DATA_W.
REQ-018 After the final beat of the last selected buffer is accepted, the FSM SHALL enter DONE: wr_en=0, done=1 for exactly that one cycle, then IDLE.
REQ-019 busy SHALL be 1 in RUN and DONE, 0 in IDLE.
REQ-020 abort=1 in RUN or DONE SHALL return to IDLE next edge with wr_en=0, done=0; abort has priority over beat acceptance and start; abort in IDLE has no effect.
REQ-021 A beat presented with wr_ready=0 at abort SHALL be dropped, not completed.

Reset
REQ-022 reset_n=0 SHALL asynchronously force IDLE, wr_en=0, done=0, busy=0, wr_addr=0, wr_data0=0, wr_data1=0, x=y=0, loc=0.
REQ-023 Reset asserted mid-fill SHALL abandon the fill; no beat SHALL be issued until a new start after reset_n=1.

Verification (H_ACTIVE=8, V_ACTIVE=4, BUF_STRIDE=64, CHECK_LOG2=1, NUM_BUFS=2)
REQ-024 Mode 0, buf_mask=2'b11, wr_ready=1 -> 64 beats in 64 consecutive cycles, addrs 0..31 then 64..95, buffer 0 data toggles per 2 pixels, buffer 1 per 4, done pulse at cycle 65 after start.
REQ-025 Mode 3, buf_mask=2'b10, wr_ready toggling 1/0 every cycle -> 32 accepted beats addr 64..95, data equals addr, outputs stable on every ready=0 cycle.
REQ-026 buf_mask=0, start=1 -> no wr_en, done=1 one cycle after start, busy high only that cycle.
REQ-027 Mode 1 fill, abort at beat 10 with wr_ready=0 -> wr_en=0 next cycle, no done, busy=0, later start restarts at addr 0.
REQ-028 reset_n low asynchronously mid-fill (between edges) -> all outputs 0 immediately; start during RUN ignored; line wrap 7->0 with y+1 verified in every run.
